// File: rtl/memoria_dual_lectura_if.sv
//============================================================================
// Module : memoria_dual_lectura_if
// Brief  : Bus between the memory stimulus generator and the dual-read RAM.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface memoria_dual_lectura_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] validdata;
  logic                  iWriteEnable;
  logic                  Readtoa;
  logic                  Readtob;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] oDataA;
  logic [DATA_WIDTH-1:0] oDataB;
  logic                  oValidA;
  logic                  oValidB;
  logic                  oUnwritten;
  logic [ADDR_WIDTH:0]   oCount;

  modport master (
    output validdata, iWriteEnable, Readtoa, Readtob, iAddress,
    input  oDataA, oDataB, oValidA, oValidB, oUnwritten, oCount
  );

  modport slave (
    input  validdata, iWriteEnable, Readtoa, Readtob, iAddress,
    output oDataA, oDataB, oValidA, oValidB, oUnwritten, oCount
  );
endinterface

`default_nettype wire

// File: rtl/memoria_dual_lectura.sv
//============================================================================
// Module : memoria_dual_lectura
// Brief  : 1024x8 synchronous RAM, one write path, two registered read ports,
//          written-address tracking and distinct-write counter.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module memoria_dual_lectura #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  memoria_dual_lectura_if.slave     bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      written_q, written_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  unw_q, unw_d;
  state_t                state_a_q, state_a_d;
  state_t                state_b_q, state_b_d;

  logic                  was_written;
  logic                  any_read;
  logic [DATA_WIDTH-1:0] rd_word;

  assign was_written = written_q[bus.iAddress];
  assign any_read    = bus.Readtoa | bus.Readtob;

  // Write-first bypass; unwritten locations read as zero because the array
  // itself is never cleared.
  always_comb begin
    rd_word = '0;
    if (bus.iWriteEnable) begin
      rd_word = bus.validdata;
    end else if (was_written) begin
      rd_word = mem_q[bus.iAddress];
    end
  end

  always_comb begin
    written_d = written_q;
    count_d   = count_q;
    if (bus.iWriteEnable) begin
      written_d[bus.iAddress] = 1'b1;
      if (!was_written && (count_q != C_DEPTH)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    unw_d    = any_read & ~was_written & ~bus.iWriteEnable;
    if (bus.Readtoa) data_a_d = rd_word;
    if (bus.Readtob) data_b_d = rd_word;
  end

  always_comb begin
    state_a_d = IDLE;
    state_b_d = IDLE;
    case (state_a_q)
      IDLE:    state_a_d = bus.Readtoa ? VALID : IDLE;
      VALID:   state_a_d = bus.Readtoa ? VALID : IDLE;
      default: state_a_d = IDLE;
    endcase
    case (state_b_q)
      IDLE:    state_b_d = bus.Readtob ? VALID : IDLE;
      VALID:   state_b_d = bus.Readtob ? VALID : IDLE;
      default: state_b_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.iWriteEnable) begin
      mem_q[bus.iAddress] <= bus.validdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
      count_q   <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      unw_q     <= 1'b0;
      state_a_q <= IDLE;
      state_b_q <= IDLE;
    end else begin
      written_q <= written_d;
      count_q   <= count_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      unw_q     <= unw_d;
      state_a_q <= state_a_d;
      state_b_q <= state_b_d;
    end
  end

  assign bus.oDataA     = data_a_q;
  assign bus.oDataB     = data_b_q;
  assign bus.oValidA    = (state_a_q == VALID);
  assign bus.oValidB    = (state_b_q == VALID);
  assign bus.oUnwritten = unw_q;
  assign bus.oCount     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_memoria_dual_lectura.sv
//============================================================================
// Module : tb_memoria_dual_lectura
// Brief  : Directed vector table plus reset and saturation sequences.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_memoria_dual_lectura;

  localparam int DW = 8;
  localparam int AW = 10;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  memoria_dual_lectura_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memoria_dual_lectura #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic          ra;
    logic          rb;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_va;
    logic          exp_vb;
    logic          exp_unw;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic ra, logic rb, int addr, int din,
                              int ea, int eb, logic va, logic vb, logic unw, int cnt);
    vec_t v;
    v.we = we; v.ra = ra; v.rb = rb;
    v.addr = AW'(addr); v.din = DW'(din);
    v.exp_a = DW'(ea); v.exp_b = DW'(eb);
    v.exp_va = va; v.exp_vb = vb; v.exp_unw = unw; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, int ea, int eb, logic va, logic vb,
                            logic unw, int cnt);
    chk({tag, ".oDataA"},     int'(bus.oDataA),     ea);
    chk({tag, ".oDataB"},     int'(bus.oDataB),     eb);
    chk({tag, ".oValidA"},    int'(bus.oValidA),    int'(va));
    chk({tag, ".oValidB"},    int'(bus.oValidB),    int'(vb));
    chk({tag, ".oUnwritten"}, int'(bus.oUnwritten), int'(unw));
    chk({tag, ".oCount"},     int'(bus.oCount),     cnt);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(logic we, logic ra, logic rb, int addr, int din);
    @(negedge clk);
    bus.iWriteEnable = we;
    bus.Readtoa      = ra;
    bus.Readtob      = rb;
    bus.iAddress     = AW'(addr);
    bus.validdata    = DW'(din);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.iWriteEnable = 1'b0;
    bus.Readtoa      = 1'b0;
    bus.Readtob      = 1'b0;
    bus.iAddress     = '0;
    bus.validdata    = '0;

    //              we ra rb addr   din    expA   expB  vA vB unw cnt
    vecs.push_back(mk(1, 0, 0, 0,     8,     0,     0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,     0,     8,     0,    1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 10,    16,    8,     0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 10,    0,     8,     16,   0, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 'h1F,  32,    8,     16,   0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 'h3FF, 64,    8,     16,   0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 'h3FF, 0,     64,    64,   1, 1, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0,     'hAA,  64,    64,   0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0,     'hAA,  64,    64,   0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0,     'hAA,  64,    64,   0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0,     0,     'hAA,  64,   1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 'h1F,  0,     32,    64,   1, 0, 0, 4));
    vecs.push_back(mk(1, 1, 0, 5,     'h5A,  'h5A,  64,   1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 1, 100,   0,     'h5A,  0,    0, 1, 1, 5));
    vecs.push_back(mk(0, 0, 0, 100,   0,     'h5A,  0,    0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 1, 'h3FF, 0,     'h5A,  64,   0, 1, 0, 5));

    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].ra, vecs[i].rb, int'(vecs[i].addr), int'(vecs[i].din));
      check_outs($sformatf("vec%0d", i), int'(vecs[i].exp_a), int'(vecs[i].exp_b),
                 vecs[i].exp_va, vecs[i].exp_vb, vecs[i].exp_unw, vecs[i].exp_cnt);
    end

    // Asynchronous reset mid-cycle while a read is set up for the next edge.
    drive(0, 1, 1, 10, 0);
    check_outs("pre_rst", 16, 16, 1, 1, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    drive(0, 1, 0, 0, 0);
    check_outs("post_rst_rd", 0, 0, 1, 0, 1, 0);

    // Fill every address to reach the saturation point.
    for (int a = 0; a < 1024; a++) begin
      drive(1, 0, 0, a, a & 'hFF);
    end
    check_outs("fill", 0, 0, 0, 0, 0, 1024);
    drive(1, 0, 0, 7, 'h11);
    check_outs("sat_rewrite", 0, 0, 0, 0, 0, 1024);
    drive(0, 1, 1, 'h3FF, 0);
    check_outs("rd_3ff", 'hFF, 'hFF, 1, 1, 0, 1024);
    drive(0, 0, 1, 7, 0);
    check_outs("rd_7", 'hFF, 'h11, 0, 1, 0, 1024);
    drive(0, 1, 0, 0, 0);
    check_outs("rd_0", 0, 'h11, 1, 0, 0, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/memoria_dual_lectura.md
Name: memoria_dual_lectura

Overview:
- Responder for the memory stimulus interface: a 1024x8 synchronous RAM with one write path and two independent registered read outputs, A and B.
- Sits behind the stimulus generator (validdata, Readtoa, Readtob, iWriteEnable, iAddress).
- Tracks which addresses have been written, flags reads of unwritten locations, and counts distinct written addresses.

Parameters:
- DATA_WIDTH, 8, width of stored words and of validdata/oDataA/oDataB.
- ADDR_WIDTH, 10, width of iAddress.
- DEPTH, 1024, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- validdata  input  DATA_WIDTH  write data.
- iWriteEnable  input  1  write strobe, sampled at rising clk.
- Readtoa  input  1  read request routed to port A.
- Readtob  input  1  read request routed to port B.
- iAddress  input  ADDR_WIDTH  shared address for write and reads.
- oDataA  output  DATA_WIDTH  registered read data, port A.
- oDataB  output  DATA_WIDTH  registered read data, port B.
- oValidA  output  1  one-cycle pulse: oDataA updated this cycle.
- oValidB  output  1  one-cycle pulse: oDataB updated this cycle.
- oUnwritten  output  1  one-cycle pulse: a read hit a never-written address.
- oCount  output  ADDR_WIDTH+1  number of distinct addresses written since reset (0..1024).

Behaviour:
- Reset (async, reset=1):
  - Clears oDataA, oDataB, oValidA, oValidB, oUnwritten, oCount and the 1024-entry written[] bit vector to 0 immediately.
  - Array contents are not cleared.
  - Reset mid-operation aborts any in-flight read; the outputs read 0 on the first edge after release.
- Write, iWriteEnable=1 at a rising edge:
  - mem[iAddress] <= validdata and written[iAddress] <= 1.
  - If written[iAddress] was 0, oCount increments by 1. Rewrites do not change oCount. oCount saturates at DEPTH.
- Read, Readtoa=1 and/or Readtob=1 at a rising edge:
  - Latency is 1 clock: data appears on the selected oData* port after that edge, with oValid* = 1 for exactly that cycle.
  - Non-selected ports hold their previous oData* value; their oValid* is 0.
  - Readtoa and Readtob both high: both ports load the same word and both valids pulse.
- Read-during-write, same edge, same address: write-first. The read port returns the new validdata, and the location counts as written, so oUnwritten = 0.
- Unwritten read: when written[iAddress] = 0 and no same-edge write targets it, the selected port(s) load 0 and oUnwritten pulses 1 with oValid*.
- Held inputs:
  - A request held high for N edges produces N reads, with oValid* high continuously.
  - A write held for N edges rewrites the same word with no oCount change after the first edge.
- No request at an edge: oValid* and oUnwritten go to 0; oData* hold.
- Address wrap: full 10-bit range valid; 10'h3FF and 10'h000 are independent locations; there is no out-of-range case.
- Internal control is a per-port 2-state FSM (IDLE, VALID):
  - IDLE->VALID on a request edge.
  - VALID->VALID on a repeated request.
  - VALID->IDLE on no request.
  - The FSM drives oValid*.

Test Plan:
- Reset, then write validdata=8 @addr 0, then Readtoa @addr 0 -> next edge oDataA=8, oValidA=1, oValidB=0, oCount=1.
- Write 16 @addr 10, then Readtob @addr 10 -> oDataB=16, oValidB=1; oDataA stays 8; oCount=2.
- Write 32 @10'h01F, write 64 @10'h3FF, then Readtoa=Readtob=1 @10'h3FF -> oDataA=oDataB=64, both valids 1, oCount=4.
- Rewrite 8'hAA @addr 0 for 3 edges -> oCount unchanged at 4; Readtoa @0 returns 8'hAA.
- Same-edge iWriteEnable + Readtoa @addr 5, validdata=8'h5A -> oDataA=8'h5A, oUnwritten=0, oCount increments.
- Readtob @ never-written addr 100 -> oDataB=0, oValidB=1, oUnwritten=1. Then assert reset asynchronously mid-cycle -> all outputs 0 immediately; Readtoa @0 after release -> oUnwritten=1, oDataA=0.
